touch_key_filter: RTL and testbench

TOUCH_KEY_FILTER -- requirements
Module: touch_key_filter

---
 rtl/touch_key_filter.sv | 139 +++++++++++++
 tb/tb_touch_key_filter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/touch_key_filter.sv
// Touch pad conditioner: synchronizes the raw pad level, debounces press and
// release, and emits one-cycle touch / long-press / release pulses.
module touch_key_filter #(
    parameter int DEB_CNT  = 1_000_000,
    parameter int LONG_CNT = 50_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic touch_key,
    output logic touch_flag,
    output logic long_flag,
    output logic release_flag,
    output logic key_level
);

    localparam int CNT_W = 32;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_RELEASE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             long_done_q, long_done_d;
    logic             touch_flag_q, touch_flag_d;
    logic             long_flag_q, long_flag_d;
    logic             release_flag_q, release_flag_d;
    logic             key_level_q, key_level_d;
    logic             key_meta_q, key_s_q;

    // Both flops reset to the idle level so reset never looks like a touch.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_meta_q <= 1'b1;
            key_s_q    <= 1'b1;
        end else begin
            key_meta_q <= touch_key;
            key_s_q    <= key_meta_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= IDLE;
            deb_cnt_q      <= '0;
            hold_cnt_q     <= '0;
            long_done_q    <= 1'b0;
            touch_flag_q   <= 1'b0;
            long_flag_q    <= 1'b0;
            release_flag_q <= 1'b0;
            key_level_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            deb_cnt_q      <= deb_cnt_d;
            hold_cnt_q     <= hold_cnt_d;
            long_done_q    <= long_done_d;
            touch_flag_q   <= touch_flag_d;
            long_flag_q    <= long_flag_d;
            release_flag_q <= release_flag_d;
            key_level_q    <= key_level_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d        = state_q;
        deb_cnt_d      = deb_cnt_q;
        hold_cnt_d     = hold_cnt_q;
        long_done_d    = long_done_q;
        touch_flag_d   = 1'b0;
        long_flag_d    = 1'b0;
        release_flag_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!key_s_q) begin
                    state_d   = DEB_PRESS;
                    deb_cnt_d = '0;
                end
            end
            DEB_PRESS: begin
                if (key_s_q) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d      = PRESSED;
                    hold_cnt_d   = '0;
                    long_done_d  = 1'b0;
                    touch_flag_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (key_s_q) begin
                    // hold_cnt is kept so a release bounce does not restart the hold.
                    state_d   = DEB_RELEASE;
                    deb_cnt_d = '0;
                end else begin
                    if (hold_cnt_q != LONG_LAST) begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end else if (!long_done_q) begin
                        long_flag_d = 1'b1;
                        long_done_d = 1'b1;
                    end
                end
            end
            DEB_RELEASE: begin
                if (!key_s_q) begin
                    state_d = PRESSED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d        = IDLE;
                    release_flag_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        key_level_d = !(state_d == PRESSED || state_d == DEB_RELEASE);
    end

    assign touch_flag   = touch_flag_q;
    assign long_flag    = long_flag_q;
    assign release_flag = release_flag_q;
    assign key_level    = key_level_q;

endmodule

// File: tb/tb_touch_key_filter.sv
// Self-checking bench for touch_key_filter with DEB_CNT=4, LONG_CNT=20.
module tb_touch_key_filter;

    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic touch_key = 1'b1;
    logic touch_flag, long_flag, release_flag, key_level;

    touch_key_filter #(.DEB_CNT(DEB), .LONG_CNT(LONG)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .touch_key    (touch_key),
        .touch_flag   (touch_flag),
        .long_flag    (long_flag),
        .release_flag (release_flag),
        .key_level    (key_level)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cnt_touch, cnt_long, cnt_rel;

    // Reference model: the accepted level flips once DEB+1 consecutive
    // synchronized samples disagree with it; a long press is the LONG-th
    // steady-pressed sample after acceptance.
    bit m_d1, m_d2, m_level, m_long_done;
    int m_run, m_hold;
    bit e_touch, e_long, e_rel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0d, wanted %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_d1 = 1'b1; m_d2 = 1'b1; m_level = 1'b1; m_long_done = 1'b0;
        m_run = 0; m_hold = 0;
        e_touch = 1'b0; e_long = 1'b0; e_rel = 1'b0;
    endtask

    task automatic model_step(input bit raw);
        bit ks;
        ks = m_d2;
        m_d2 = m_d1;
        m_d1 = raw;
        e_touch = 1'b0; e_long = 1'b0; e_rel = 1'b0;
        if (ks != m_level) begin
            m_run++;
            if (m_run == DEB + 1) begin
                m_level = ks;
                m_run   = 0;
                if (!ks) begin
                    e_touch = 1'b1; m_hold = 0; m_long_done = 1'b0;
                end else begin
                    e_rel = 1'b1;
                end
            end
        end else begin
            if (!m_level && m_run == 0) begin
                m_hold++;
                if (m_hold >= LONG && !m_long_done) begin
                    e_long = 1'b1; m_long_done = 1'b1;
                end
            end
            m_run = 0;
        end
    endtask

    // One clock: model sees the value the DUT samples, then the next input
    // is driven, then outputs are compared mid-cycle.
    task automatic cycle(input logic k);
        @(posedge sys_clk);
        if (sys_rst_n) model_step(touch_key);
        #2 touch_key = k;
        @(negedge sys_clk);
        check("touch_flag", touch_flag, e_touch);
        check("long_flag", long_flag, e_long);
        check("release_flag", release_flag, e_rel);
        check("key_level", key_level, m_level);
        check("exclusive", (32'(touch_flag) + 32'(long_flag) + 32'(release_flag)) <= 1, 1);
        cnt_touch += int'(touch_flag);
        cnt_long  += int'(long_flag);
        cnt_rel   += int'(release_flag);
    endtask

    task automatic do_reset(input logic v);
        sys_rst_n = 1'b0;
        touch_key = v;
        model_reset();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cnt_touch = 0; cnt_long = 0; cnt_rel = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_touch"}, touch_flag, 0);
        check({tag, "_long"}, long_flag, 0);
        check({tag, "_release"}, release_flag, 0);
        check({tag, "_level"}, key_level, 1);
    endtask

    typedef struct {
        string name;
        int    lo1, hi1, lo2, hi2;
        int    exp_touch, exp_long, exp_rel;
        logic  exp_level;
    } vec_t;

    function automatic vec_t mk(input string n, input int a, input int b, input int c, input int d,
                                input int t, input int l, input int r, input logic lv);
        vec_t v;
        v.name = n; v.lo1 = a; v.hi1 = b; v.lo2 = c; v.hi2 = d;
        v.exp_touch = t; v.exp_long = l; v.exp_rel = r; v.exp_level = lv;
        return v;
    endfunction

    vec_t vecs[7];

    initial begin
        logic last;

        vecs[0] = mk("tap",           8, 30,  0,  0, 1, 0, 1, 1'b1);
        vecs[1] = mk("glitch",        3, 20,  0,  0, 0, 0, 0, 1'b1);
        vecs[2] = mk("press_bounce",  2,  1, 10,  0, 1, 0, 0, 1'b0);
        vecs[3] = mk("long_hold",    40, 30,  0,  0, 1, 1, 1, 1'b1);
        vecs[4] = mk("rel_bounce",   12,  2,  1, 30, 1, 0, 1, 1'b1);
        vecs[5] = mk("double_tap",    8,  8,  8, 30, 2, 0, 2, 1'b1);
        vecs[6] = mk("long_bounce",  30,  2, 10, 30, 1, 1, 1, 1'b1);

        do_reset(1'b1);
        check_reset_values("post_reset");

        // Clean press: first sampled low at edge 10, pulse after edge 16.
        do_reset(1'b1);
        for (int e = 1; e <= 24; e++) begin
            cycle((e >= 9) ? 1'b0 : 1'b1);
            if (e >= 10) begin
                check("clean_touch_timing", touch_flag, (e == 16) ? 1 : 0);
                check("clean_level", key_level, (e < 16) ? 1 : 0);
            end
        end

        // Key already low through reset: full debounce after release.
        do_reset(1'b0);
        for (int e = 1; e <= 12; e++) begin
            cycle(1'b0);
            check("held_in_reset_touch", touch_flag, (e == 7) ? 1 : 0);
        end

        // Table of press/release patterns.
        foreach (vecs[i]) begin
            do_reset(1'b1);
            last = 1'b1;
            repeat (vecs[i].lo1) begin cycle(1'b0); last = 1'b0; end
            repeat (vecs[i].hi1) begin cycle(1'b1); last = 1'b1; end
            repeat (vecs[i].lo2) begin cycle(1'b0); last = 1'b0; end
            repeat (vecs[i].hi2) begin cycle(1'b1); last = 1'b1; end
            repeat (12) cycle(last);
            check({vecs[i].name, "_touches"}, cnt_touch, vecs[i].exp_touch);
            check({vecs[i].name, "_longs"}, cnt_long, vecs[i].exp_long);
            check({vecs[i].name, "_releases"}, cnt_rel, vecs[i].exp_rel);
            check({vecs[i].name, "_level"}, key_level, vecs[i].exp_level);
        end

        // Reset in the middle of press debounce.
        do_reset(1'b1);
        repeat (4) cycle(1'b0);
        #1 sys_rst_n = 1'b0;
        model_reset();
        #1 check_reset_values("rst_deb_press");
        touch_key = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cnt_touch = 0; cnt_long = 0; cnt_rel = 0;
        repeat (15) cycle(1'b1);
        check("rst_deb_press_no_pulse", cnt_touch + cnt_long + cnt_rel, 0);

        // Reset while pressed.
        do_reset(1'b1);
        repeat (12) cycle(1'b0);
        check("pressed_before_reset", key_level, 0);
        #1 sys_rst_n = 1'b0;
        model_reset();
        #1 check_reset_values("rst_pressed");
        touch_key = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cnt_touch = 0; cnt_long = 0; cnt_rel = 0;
        repeat (15) cycle(1'b1);
        check("rst_pressed_no_pulse", cnt_touch + cnt_long + cnt_rel, 0);
        check("rst_pressed_level", key_level, 1);

        // Random bursts against the reference model.
        do_reset(1'b1);
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(1, 30)) cycle(1'b0);
            repeat ($urandom_range(1, 12)) cycle(1'b1);
        end
        repeat (12) cycle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
